ram_arbiter: RTL and testbench

- Two-requester controller sharing the single-port synchronous 512x32 RAM.
  - Requester 0 is instruction fetch (read-only).
  - Requester 1 is the datapath load/store unit (read or write).
- Sequences every RAM access through a fixed 3-state FSM: sample/grant, access, respond.
- Guarantees Read and Write are never asserted together and returns read data with a one-cycle ack.
- Sits between the CPU control unit / MDR logic and the RAM.

---
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port synchronous RAM between two requesters. Requester 0
//   is instruction fetch (read-only). Requester 1 is the load/store unit (read
//   or write). Every access walks IDLE -> ACCESS -> RESP, so mem_read and
//   mem_write are each high for exactly one cycle and are never high together.
//   The acked requester sees its result one cycle after the RESP edge.
//
// Ports
//   clk, reset_n          : clock (posedge) and asynchronous active-low reset
//   f_req/f_addr/f_ack    : fetch request, address, one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_ack         : data request, write enable, address, write data,
//                           one-cycle completion pulse
//   rdata                 : read data for the requester currently being acked
//   mem_read/mem_write/
//   mem_addr/mem_wdata    : registered RAM control, address and write data
//   mem_rdata             : RAM output, valid one cycle after the Read edge
//   busy                  : high in every state except IDLE
//   xfer_count            : completed transactions, wraps to zero
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16   // width of xfer_count; 16 in normal use
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t r_state;
  logic   r_gnt;        // port owning the current transaction
  logic   r_last_grant; // port served by the most recent completed transaction
  logic   r_we;         // latched write flag of the current transaction

  logic   w_any_req;
  logic   w_pick_d;

  // Round-robin: data wins only if fetch is idle or fetch was served last.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_any_req = f_req | d_req;
    w_pick_d  = 1'b0;
    if (d_req && (!f_req || (r_last_grant == PORT_F))) begin
      w_pick_d = 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register, as real flops do.
  // NOTE: all control and data outputs are reset asynchronously so an
  // abandoned transaction drops RAM strobes and acks immediately, not at the
  // next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= PORT_F;
      r_last_grant <= PORT_D;   // fetch wins the first tie after reset
      r_we         <= 1'b0;
      f_ack        <= 1'b0;
      d_ack        <= 1'b0;
      rdata        <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      xfer_count   <= '0;
    end else begin
      // Acks are single-cycle pulses; only RESP raises one.
      f_ack <= 1'b0;
      d_ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt <= w_pick_d ? PORT_D : PORT_F;
            if (w_pick_d) begin
              r_we      <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_read  <= !d_we;
              mem_write <= d_we;
            end else begin
              r_we      <= 1'b0;
              mem_addr  <= f_addr;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
            r_state <= S_ACCESS;
          end
        end

        // The RAM acts on the edge that ends this state; drop the strobes.
        S_ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          r_state   <= S_RESP;
        end

        S_RESP: begin
          if (!r_we) begin
            rdata <= mem_rdata;
          end
          if (r_gnt == PORT_D) begin
            d_ack <= 1'b1;
          end else begin
            f_ack <= 1'b1;
          end
          r_last_grant <= r_gnt;
          xfer_count   <= xfer_count + CNT_W'(1);
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The RAM must never see Read and Write together.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 512x32 synchronous RAM.
//   Stimulus pushes the hand-computed expected acks (port + rdata) into a
//   scoreboard queue in expected grant order; a negedge monitor pops and
//   compares on every ack. A second, narrow-counter instance covers the
//   xfer_count wrap.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [15:0]       xfer_count;

  // Signals of the wrap-test instance (4-bit counter).
  logic              wf_req;
  logic [ADDR_W-1:0] wf_addr;
  logic              wf_ack;
  logic              wd_ack;
  logic [DATA_W-1:0] w_rdata;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_busy;
  logic [3:0]        w_xfer_count;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_ack      (f_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .rdata      (rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) u_wrap (
    .clk        (clk),
    .reset_n    (reset_n),
    .f_req      (wf_req),
    .f_addr     (wf_addr),
    .f_ack      (wf_ack),
    .d_req      (1'b0),
    .d_we       (1'b0),
    .d_addr     ('0),
    .d_wdata    ('0),
    .d_ack      (wd_ack),
    .rdata      (w_rdata),
    .mem_read   (w_mem_read),
    .mem_write  (w_mem_write),
    .mem_addr   (w_mem_addr),
    .mem_wdata  (w_mem_wdata),
    .mem_rdata  (32'h0),
    .busy       (w_busy),
    .xfer_count (w_xfer_count)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM
  logic [DATA_W-1:0] ram [512];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata     <= ram[mem_addr];
  end

  // Checking infrastructure
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic [31:0] data;   // rdata expected while the ack is high
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_ack(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: strobe counters and scoreboard comparison, sampled on negedge.
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;

  always @(negedge clk) begin
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read)  last_rd_addr <= mem_addr;
    if (mem_read || mem_write)
      check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    if (f_ack || d_ack) begin
      check("ack_onehot", 32'(f_ack & d_ack), 32'd0);
      check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_port", 32'(d_ack), 32'(e.port));
        check("ack_rdata", rdata, e.data);
      end
    end
  end

  // Raise one request and hold it until its ack; returns ack latency in
  // negedges after the raise (-1 on timeout). Called at a negedge.
  task automatic do_req(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input bit scramble, output int lat);
    lat = -1;
    if (port == 1'b0) begin
      f_req  = 1'b1;
      f_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wd;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      // After the grant edge the arbiter must use its latched copies.
      if (scramble && i == 1 && port == 1'b1) begin
        d_addr  = ~addr;
        d_wdata = ~wd;
      end
      if ((port == 1'b0 && f_ack) || (port == 1'b1 && d_ack)) begin
        lat = i;
        break;
      end
    end
    if (port == 1'b0) f_req = 1'b0;
    else              d_req = 1'b0;
    check("ack_timeout", 32'(lat > 0), 32'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int c0;
    int rd0;
    int wr0;

    for (int i = 0; i < 512; i++) ram[i] = '0;
    ram[0]     = 32'h00800075;
    ram[9'h75] = 32'h0000EADF;

    reset_n = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    wf_req = 1'b0; wf_addr = '0;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {27'd0, busy, mem_read, mem_write, f_ack, d_ack}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_xfer", 32'(xfer_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single fetch from address 0
    rd0 = rd_cnt;
    expect_ack(1'b0, 32'h00800075);
    do_req(1'b0, 1'b0, 9'h000, '0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_xfer", 32'(xfer_count), 32'd1);
    check("t1_read_once", 32'(rd_cnt - rd0), 32'd1);
    check("t1_read_addr", 32'(last_rd_addr), 32'h000);
    @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);

    // 1b: simultaneous requests with fetch served last -> data first
    expect_ack(1'b1, 32'h00800075);
    expect_ack(1'b0, 32'h0000EADF);
    fork
      begin int l; do_req(1'b1, 1'b0, 9'h000, '0, 1'b0, l); end
      begin int l; do_req(1'b0, 1'b0, 9'h075, '0, 1'b0, l); end
    join
    @(negedge clk);
    check("t1b_xfer", 32'(xfer_count), 32'd3);

    // 2: write then read back at 0x90; rdata holds across the write ack
    wr0 = wr_cnt;
    expect_ack(1'b1, 32'h0000EADF);
    do_req(1'b1, 1'b1, 9'h090, 32'h12345678, 1'b1, lat);
    check("t2_write_once", 32'(wr_cnt - wr0), 32'd1);
    check("t2_ram_content", ram[9'h090], 32'h12345678);
    @(negedge clk);
    expect_ack(1'b1, 32'h12345678);
    do_req(1'b1, 1'b0, 9'h090, '0, 1'b0, lat);
    check("t2_read_latency", 32'(lat), 32'd3);
    @(negedge clk);
    check("t2_xfer", 32'(xfer_count), 32'd5);

    // 3: both requesters busy for 4 transactions -> F, D, F, D in 12 cycles
    expect_ack(1'b0, 32'h00800075);
    expect_ack(1'b1, 32'h12345678);
    expect_ack(1'b0, 32'h00800075);
    expect_ack(1'b1, 32'h12345678);
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          int l;
          do_req(1'b0, 1'b0, 9'h000, '0, 1'b0, l);
          if (i == 0) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int l;
          do_req(1'b1, 1'b0, 9'h090, '0, 1'b0, l);
          if (i == 0) @(negedge clk);
        end
      end
    join
    check("t3_cycles", 32'(cyc - c0), 32'd12);
    check("t3_xfer", 32'(xfer_count), 32'd9);
    @(negedge clk);

    // 4: data streaming, fetch arrives during a data RESP -> served next
    expect_ack(1'b1, 32'h12345678);
    expect_ack(1'b0, 32'h00800075);
    expect_ack(1'b1, 32'h12345678);
    expect_ack(1'b1, 32'h12345678);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int l;
          do_req(1'b1, 1'b0, 9'h090, '0, 1'b0, l);
          @(negedge clk);
        end
      end
      begin
        int l;
        repeat (2) @(negedge clk);
        do_req(1'b0, 1'b0, 9'h000, '0, 1'b0, l);
        check("t4_fetch_latency", 32'(l), 32'd4);
      end
    join
    check("t4_xfer", 32'(xfer_count), 32'd13);

    // 5: reset during ACCESS of a fetch at 0x75 -> outputs clear, no ack
    f_req  = 1'b1;
    f_addr = 9'h075;
    @(negedge clk);
    check("t5_in_access", {30'd0, mem_read, busy}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_reset_ctrl", {27'd0, busy, mem_read, mem_write, f_ack, d_ack}, 32'd0);
    check("t5_reset_rdata", rdata, 32'd0);
    check("t5_reset_addr", 32'(mem_addr), 32'd0);
    check("t5_reset_xfer", 32'(xfer_count), 32'd0);
    f_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 5b: fresh tie after reset -> fetch first, then data
    expect_ack(1'b0, 32'h0000EADF);
    expect_ack(1'b1, 32'h12345678);
    fork
      begin int l; do_req(1'b0, 1'b0, 9'h075, '0, 1'b0, l); end
      begin int l; do_req(1'b1, 1'b0, 9'h090, '0, 1'b0, l); end
    join
    @(negedge clk);
    check("t5_xfer", 32'(xfer_count), 32'd2);

    // 6: counter wrap on the narrow-counter instance (16 fetches)
    for (int n = 1; n <= 16; n++) begin
      bit got;
      got = 1'b0;
      wf_req  = 1'b1;
      wf_addr = 9'(n);
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (wf_ack) got = 1'b1;
      end
      wf_req = 1'b0;
      if (!got) check("t6_ack_timeout", 32'(got), 32'd1);
      if (n == 15) check("t6_count_max", 32'(w_xfer_count), 32'd15);
      @(negedge clk);
    end
    check("t6_count_wrap", 32'(w_xfer_count), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
